gate_mac: RTL and testbench
===========================

# gate_mac

Pre-activation dot-product unit for the LSTM gate datapath. It accumulates a bias plus NELEM weight×input products in signed fixed point. It rounds and saturates the sum to BITWIDTH bits and presents it as the `operand` of the downstream `sigmoid`/tanh stage. One instance is used per gate row; a result is produced once per start/NELEM-beat transaction.

## Interface
- BITWIDTH, 18: width of weights, inputs, bias and result (two's complement).
- FRACWIDTH, 12: fractional bits of every BITWIDTH-bit quantity (1.0 = 4096).
- NELEM, 8: products per dot product (≥1).
- ACCWIDTH, 40: accumulator width; must be ≥ 2·BITWIDTH + ceil(log2(NELEM+1)).
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin transaction; sampled only in IDLE.
- bias  in  BITWIDTH  bias term, sampled with accepted start.
- in_valid  in  1  weight/xin beat valid.
- in_ready  out  1  high in ACCUM only; a beat transfers when in_valid & in_ready.
- weight  in  BITWIDTH  weight element.
- xin  in  BITWIDTH  input-vector element.
- busy  out  1  high in any state other than IDLE.
- result  out  BITWIDTH  rounded, saturated dot product; holds until the next result.
- result_valid  out  1  one-cycle pulse marking a new result.

## Operation
- States: IDLE, ACCUM, DRAIN, OUTPUT.
- IDLE:
  - start=1: acc <= sign_extend(bias) << FRACWIDTH; cnt <= 0; go to ACCUM.
  - in_valid is ignored.
- ACCUM:
  - Each transfer registers p <= signed(weight)·signed(xin), 2·BITWIDTH bits with 2·FRACWIDTH frac bits.
  - Each transfer sets p_valid <= 1 and increments cnt.
  - The transfer with cnt == NELEM-1 moves to DRAIN.
  - in_valid=0 cycles stall without effect.
- Accumulate stage, every state: if p_valid, acc <= acc + sign_extend(p); p_valid clears unless a new transfer occurs.
- DRAIN: one cycle, so the last product is added; go to OUTPUT.
- OUTPUT:
  - r = (acc + 2^(FRACWIDTH-1)) >>> FRACWIDTH, i.e. round half up, arithmetic shift.
  - result <= r clamped to [-2^(BITWIDTH-1), 2^(BITWIDTH-1)-1].
  - result_valid <= 1; go to IDLE.
- start is ignored while busy. start in the cycle result_valid is high (state IDLE) is accepted: back-to-back transactions.
- Accumulator never wraps when ACCWIDTH satisfies its rule. Saturation applies only at OUTPUT.
- Reset values: state IDLE; result 0; result_valid 0; in_ready 0; busy 0; acc 0; cnt 0; p_valid 0.
- Reset mid-transaction aborts it; no result_valid is produced, and result returns to 0.

## Timing
- start accepted at edge S; in_ready is high from the cycle after S.
- The first beat can transfer at edge S+1.
- Last beat accepted at edge L (ACCUM -> DRAIN):
  - L+1: acc includes last product, state OUTPUT.
  - L+2: result updated, result_valid=1 for the cycle after L+2.
- Minimum transaction: start to result_valid = NELEM + 3 edges. Back-to-back period = NELEM + 3 cycles.
- in_ready falls in the cycle after the last transfer. A beat presented then is not consumed.
- result_valid is high for exactly one cycle per completed transaction.

## Test plan
- NELEM=4, bias=0, weight=4096 ×4, xin=4096, 8192, -4096, 2048 -> result=10240 (2.5); result_valid exactly 2 edges after the last beat.
- Same vectors with in_valid deasserted every other cycle, plus in_valid=1 pulses while IDLE -> identical result 10240; stray beats ignored.
- Rounding, NELEM=1, bias=0, weight=1:
  - xin=2048 -> result=1.
  - xin=-2048 -> result=0.
  - xin=-2049 -> result=-1.
- Saturation, NELEM=4, bias=131071:
  - weight=xin=131071 -> result=131071.
  - weight=131071, xin=-131072 -> result=-131072.
- Bias only: NELEM=2, bias=-4096, weights 0 -> result=-4096. start pulsed during ACCUM is ignored; cnt is unaffected.
- Reset mid-transaction: reset after 2 of 4 beats -> no result_valid, result=0, in_ready=0. Next full transaction of the first scenario -> 10240.
- Back-to-back: start asserted in the result_valid cycle -> second transaction accepted. Its result_valid follows NELEM+3 cycles later.

Source files
------------

// File: rtl/gate_mac.sv
`default_nettype none
// ============================================================================
//  Module      : gate_mac
//  Description : Signed fixed-point bias + NELEM-term dot product for one LSTM
//                gate row. The result is rounded half-up and saturated to
//                BITWIDTH bits, ready for the sigmoid/tanh stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_mac #(
  parameter int BITWIDTH  = 18,
  parameter int FRACWIDTH = 12,
  parameter int NELEM     = 8,
  parameter int ACCWIDTH  = 40
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [BITWIDTH-1:0] bias,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] weight,
  input  logic [BITWIDTH-1:0] xin,
  output logic                busy,
  output logic [BITWIDTH-1:0] result,
  output logic                result_valid
);

  localparam int c_CNT_W = (NELEM > 1) ? $clog2(NELEM) : 1;
  localparam int c_PW    = 2 * BITWIDTH;
  localparam logic [c_CNT_W-1:0]         c_LAST    = c_CNT_W'(NELEM - 1);
  localparam logic signed [ACCWIDTH-1:0] c_HALF    = ACCWIDTH'(64'd1 << (FRACWIDTH - 1));
  localparam logic signed [ACCWIDTH-1:0] c_RES_MAX = ACCWIDTH'((64'd1 << (BITWIDTH - 1)) - 64'd1);
  localparam logic signed [ACCWIDTH-1:0] c_RES_MIN = ~c_RES_MAX;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_DRAIN  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [c_CNT_W-1:0]          r_cnt;
  logic signed [ACCWIDTH-1:0]  r_acc;
  logic signed [c_PW-1:0]      r_prod;
  logic                        r_p_valid;
  logic [BITWIDTH-1:0]         r_result;
  logic                        r_result_valid;

  logic                        w_start;
  logic                        w_xfer;
  logic signed [c_PW-1:0]      w_prod;
  logic signed [ACCWIDTH-1:0]  w_bias_ext;
  logic signed [ACCWIDTH-1:0]  w_prod_ext;
  logic signed [ACCWIDTH-1:0]  w_rnd;
  logic signed [ACCWIDTH-1:0]  w_shr;
  logic [BITWIDTH-1:0]         w_sat;

  assign w_start  = start & (r_state == S_IDLE);
  assign w_xfer   = in_valid & (r_state == S_ACCUM);
  assign w_prod   = $signed(weight) * $signed(xin);

  // Bias is aligned to the product scale (2*FRACWIDTH fractional bits).
  assign w_bias_ext = {{(ACCWIDTH - BITWIDTH){bias[BITWIDTH-1]}}, bias} <<< FRACWIDTH;
  assign w_prod_ext = {{(ACCWIDTH - c_PW){r_prod[c_PW-1]}}, r_prod};

  // Round half up, then drop back to FRACWIDTH fractional bits.
  assign w_rnd = r_acc + c_HALF;
  assign w_shr = w_rnd >>> FRACWIDTH;

  // Clamp the rounded value into the representable BITWIDTH range.
  always_comb begin
    w_sat = w_shr[BITWIDTH-1:0];
    if (w_shr > c_RES_MAX) begin
      w_sat = c_RES_MAX[BITWIDTH-1:0];
    end else if (w_shr < c_RES_MIN) begin
      w_sat = c_RES_MIN[BITWIDTH-1:0];
    end
  end

  // Next-state logic for the transaction sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_ACCUM;
      S_ACCUM:  if (w_xfer && (r_cnt == c_LAST)) w_state_nxt = S_DRAIN;
      S_DRAIN:  w_state_nxt = S_OUTPUT;
      S_OUTPUT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Beat counter and product register; the product lands one cycle after its beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_prod    <= '0;
      r_p_valid <= 1'b0;
    end else begin
      r_p_valid <= w_xfer;
      if (w_start) begin
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + c_CNT_W'(1);
      end
      if (w_xfer) begin
        r_prod <= w_prod;
      end
    end
  end

  // Accumulator: loaded with the bias on start, then sums each registered product.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc <= '0;
    end else if (w_start) begin
      r_acc <= w_bias_ext;
    end else if (r_p_valid) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  // Output register: result holds between transactions, valid pulses once.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= (r_state == S_OUTPUT);
      if (r_state == S_OUTPUT) begin
        r_result <= w_sat;
      end
    end
  end

  assign in_ready     = (r_state == S_ACCUM);
  assign busy         = (r_state != S_IDLE);
  assign result       = r_result;
  assign result_valid = r_result_valid;

endmodule
`default_nettype wire

// File: tb/tb_gate_mac.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_mac
//  Description : Scoreboard bench for gate_mac. Three instances (NELEM = 4, 1,
//                2) are driven with directed vectors; expected results and
//                their arrival cycle are queued by the stimulus and checked by
//                an independent output monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_mac;

  logic              clock;
  logic              reset;
  logic              start        [3];
  logic [17:0]       bias         [3];
  logic              in_valid     [3];
  logic              in_ready     [3];
  logic [17:0]       weight       [3];
  logic [17:0]       xin          [3];
  logic              busy         [3];
  logic [17:0]       result       [3];
  logic              result_valid [3];

  typedef struct {
    int id;
    int val;
    int due;
  } exp_t;

  exp_t sbq[$];
  int   cyc;
  int   n_pass;
  int   n_total;
  bit   done;
  int   due_a;
  int   due_b;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    gate_mac #(
      .BITWIDTH (18),
      .FRACWIDTH(12),
      .NELEM    ((gi == 0) ? 4 : ((gi == 1) ? 1 : 2)),
      .ACCWIDTH (40)
    ) u_dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start[gi]),
      .bias        (bias[gi]),
      .in_valid    (in_valid[gi]),
      .in_ready    (in_ready[gi]),
      .weight      (weight[gi]),
      .xin         (xin[gi]),
      .busy        (busy[gi]),
      .result      (result[gi]),
      .result_valid(result_valid[gi])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter: at a falling edge it equals the number of rising edges so far.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Drives one transaction. Entry and exit point: 1 time unit after a rising edge.
  // Exits 1 unit after edge L+1, where L is the edge taking the last beat.
  task automatic feed(input int id, input int n, input int bv,
                      input int w[4], input int x[4],
                      input bit gap, input bit mid_start, input bit extra,
                      input int expv, output int due);
    int last;
    last = 0;
    start[id] = 1'b1;
    bias[id]  = 18'(bv);
    @(posedge clock);
    #1;
    start[id] = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (gap) begin
        in_valid[id] = 1'b0;
        @(posedge clock);
        #1;
      end
      in_valid[id] = 1'b1;
      weight[id]   = 18'(w[k]);
      xin[id]      = 18'(x[k]);
      if (mid_start && k == 0) begin
        start[id] = 1'b1;
        bias[id]  = 18'(1000);
      end
      @(negedge clock);
      chk("in_ready_beat", int'(in_ready[id]), 1);
      last = cyc + 1;
      @(posedge clock);
      #1;
      start[id] = 1'b0;
    end
    if (extra) begin
      weight[id] = 18'(131071);
      xin[id]    = 18'(131071);
    end else begin
      in_valid[id] = 1'b0;
    end
    due = last + 2;
    sbq.push_back('{id: id, val: expv, due: due});
    @(negedge clock);
    chk("in_ready_after_last", int'(in_ready[id]), 0);
    chk("busy_drain", int'(busy[id]), 1);
    @(posedge clock);
    #1;
    in_valid[id] = 1'b0;
  endtask

  initial begin
    bit prev_rv [3];
    cyc     = 0;
    n_pass  = 0;
    n_total = 0;
    done    = 1'b0;
    reset   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start[i]    = 1'b0;
      bias[i]     = '0;
      in_valid[i] = 1'b0;
      weight[i]   = '0;
      xin[i]      = '0;
      prev_rv[i]  = 1'b0;
    end

    fork
      // ---------------- stimulus ----------------
      begin
        wait_cycles(3);
        @(negedge clock);
        chk("reset_result", int'($signed(result[0])), 0);
        chk("reset_result_valid", int'(result_valid[0]), 0);
        chk("reset_in_ready", int'(in_ready[0]), 0);
        chk("reset_busy", int'(busy[0]), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_cycles(2);

        // Basic dot product; a beat held after the last one must be ignored.
        feed(0, 4, 0, '{4096, 4096, 4096, 4096}, '{4096, 8192, -4096, 2048},
             1'b0, 1'b0, 1'b1, 10240, due_a);
        wait_cycles(4);

        // Stray beats while idle, then the same vectors with gaps.
        in_valid[0] = 1'b1;
        weight[0]   = 18'(131071);
        xin[0]      = 18'(131071);
        wait_cycles(3);
        @(negedge clock);
        chk("idle_in_ready", int'(in_ready[0]), 0);
        @(posedge clock);
        #1;
        in_valid[0] = 1'b0;
        feed(0, 4, 0, '{4096, 4096, 4096, 4096}, '{4096, 8192, -4096, 2048},
             1'b1, 1'b0, 1'b0, 10240, due_a);
        wait_cycles(4);

        // Rounding on the single-element instance.
        feed(1, 1, 0, '{1, 0, 0, 0}, '{2048, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 1, due_a);
        wait_cycles(3);
        feed(1, 1, 0, '{1, 0, 0, 0}, '{-2048, 0, 0, 0}, 1'b0, 1'b0, 1'b0, 0, due_a);
        wait_cycles(3);
        feed(1, 1, 0, '{1, 0, 0, 0}, '{-2049, 0, 0, 0}, 1'b0, 1'b0, 1'b0, -1, due_a);
        wait_cycles(3);

        // Saturation at both ends.
        feed(0, 4, 131071, '{131071, 131071, 131071, 131071},
             '{131071, 131071, 131071, 131071}, 1'b0, 1'b0, 1'b0, 131071, due_a);
        wait_cycles(3);
        feed(0, 4, 131071, '{131071, 131071, 131071, 131071},
             '{-131072, -131072, -131072, -131072}, 1'b0, 1'b0, 1'b0, -131072, due_a);
        wait_cycles(3);

        // Bias only, with start pulsed during the accumulation.
        feed(2, 2, -4096, '{0, 0, 0, 0}, '{4096, 4096, 0, 0}, 1'b0, 1'b1, 1'b0, -4096, due_a);
        wait_cycles(3);

        // Abort after two of four beats.
        start[0] = 1'b1;
        bias[0]  = '0;
        @(posedge clock);
        #1;
        start[0]    = 1'b0;
        in_valid[0] = 1'b1;
        weight[0]   = 18'(4096);
        xin[0]      = 18'(4096);
        wait_cycles(2);
        in_valid[0] = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("abort_result", int'($signed(result[0])), 0);
        chk("abort_in_ready", int'(in_ready[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        wait_cycles(6);

        // Full transaction followed by a back-to-back one.
        feed(0, 4, 0, '{4096, 4096, 4096, 4096}, '{4096, 8192, -4096, 2048},
             1'b0, 1'b0, 1'b0, 10240, due_a);
        wait_cycles(1);
        feed(0, 4, 0, '{4096, 4096, 4096, 4096}, '{4096, 8192, -4096, 2048},
             1'b0, 1'b0, 1'b0, 10240, due_b);
        chk("b2b_period", due_b - due_a, 7);

        // Let the scoreboard drain, bounded.
        for (int t = 0; t < 20 && sbq.size() != 0; t++) begin
          @(posedge clock);
        end
        wait_cycles(2);
        chk("scoreboard_drain", sbq.size(), 0);
        done = 1'b1;
      end

      // ---------------- monitor ----------------
      begin
        while (!done) begin
          @(negedge clock);
          for (int id = 0; id < 3; id++) begin
            if (prev_rv[id]) begin
              chk("result_valid_pulse", int'(result_valid[id]), 0);
            end
            if (result_valid[id]) begin
              if (sbq.size() == 0) begin
                chk("unexpected_result_valid", id + 1, 0);
              end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("result_instance", id, e.id);
                chk("result_value", int'($signed(result[id])), e.val);
                chk("result_cycle", cyc, e.due);
              end
            end
            prev_rv[id] = result_valid[id];
          end
        end
      end
    join

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
